// File: rtl/digit_entry_ctrl.sv
// Keypad digit entry: builds a 3-digit BCD number and hands it to an accumulator after a range check.
// Latency: outputs 1 cycle after a key, cargar 2 cycles after ENTER; keys arriving while busy (CHECK/LOAD) are dropped.
module digit_entry_ctrl (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [9:0] acc_value,
    output logic [3:0] centenas,
    output logic [3:0] decenas,
    output logic [3:0] unidades,
    output logic       cargar,
    output logic [1:0] digit_count,
    output logic       ovf_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_CHECK = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [10:0] SUM_MAX  = 11'd1023;

    state_t     state_q, state_d;
    logic [3:0] cen_q, cen_d;
    logic [3:0] dec_q, dec_d;
    logic [3:0] uni_q, uni_d;
    logic [1:0] count_q, count_d;
    logic       cargar_q, cargar_d;
    logic       ovf_q, ovf_d;
    logic       busy_q, busy_d;

    logic        is_digit;
    logic        is_enter;
    logic        is_back;
    logic        is_clear;
    logic [10:0] sum;

    // Codes 0xD-0xF match none of these and therefore fall through untouched.
    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_enter = key_valid && (key_code == KEY_ENTER);
    assign is_back  = key_valid && (key_code == KEY_BACK);
    assign is_clear = key_valid && (key_code == KEY_CLEAR);

    assign sum = {1'b0, acc_value}
               + (11'(cen_q) * 11'd100)
               + (11'(dec_q) * 11'd10)
               + 11'(uni_q);

    always_comb begin
        state_d  = state_q;
        cen_d    = cen_q;
        dec_d    = dec_q;
        uni_d    = uni_q;
        count_d  = count_q;
        cargar_d = 1'b0;
        ovf_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (is_digit) begin
                    if (count_q == 2'd3) begin
                        ovf_d = 1'b1;
                    end else begin
                        cen_d   = dec_q;
                        dec_d   = uni_q;
                        uni_d   = key_code;
                        count_d = count_q + 2'd1;
                        state_d = ST_ENTRY;
                    end
                end else if (is_back) begin
                    if (state_q == ST_ENTRY) begin
                        uni_d   = dec_q;
                        dec_d   = cen_q;
                        cen_d   = 4'd0;
                        count_d = count_q - 2'd1;
                        if (count_q == 2'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (is_clear) begin
                    cen_d   = 4'd0;
                    dec_d   = 4'd0;
                    uni_d   = 4'd0;
                    count_d = 2'd0;
                    state_d = ST_IDLE;
                end else if (is_enter) begin
                    if (state_q == ST_ENTRY) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (sum <= SUM_MAX) begin
                    cargar_d = 1'b1;
                    state_d  = ST_LOAD;
                end else begin
                    ovf_d   = 1'b1;
                    cen_d   = 4'd0;
                    dec_d   = 4'd0;
                    uni_d   = 4'd0;
                    count_d = 2'd0;
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                // Digits stay put during the cargar cycle, cleared on the way out.
                cen_d   = 4'd0;
                dec_d   = 4'd0;
                uni_d   = 4'd0;
                count_d = 2'd0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CHECK) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            cen_q    <= 4'd0;
            dec_q    <= 4'd0;
            uni_q    <= 4'd0;
            count_q  <= 2'd0;
            cargar_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cen_q    <= cen_d;
            dec_q    <= dec_d;
            uni_q    <= uni_d;
            count_q  <= count_d;
            cargar_q <= cargar_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
        end
    end

    assign centenas    = cen_q;
    assign decenas     = dec_q;
    assign unidades    = uni_q;
    assign cargar      = cargar_q;
    assign digit_count = count_q;
    assign ovf_err     = ovf_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl with hand-computed expectations.
module tb_digit_entry_ctrl;

    logic       clk;
    logic       n_reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [9:0] acc_value;
    logic [3:0] centenas;
    logic [3:0] decenas;
    logic [3:0] unidades;
    logic       cargar;
    logic [1:0] digit_count;
    logic       ovf_err;
    logic       busy;

    int n_cmp;
    int n_err;

    localparam logic [3:0] K_ENT = 4'hA;
    localparam logic [3:0] K_BS  = 4'hB;
    localparam logic [3:0] K_CLR = 4'hC;

    digit_entry_ctrl dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .acc_value   (acc_value),
        .centenas    (centenas),
        .decenas     (decenas),
        .unidades    (unidades),
        .cargar      (cargar),
        .digit_count (digit_count),
        .ovf_err     (ovf_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Key presented for one cycle; returns 1 time unit after the sampling edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_digits(input string tag, input int c, input int d, input int u, input int n);
        chk({tag, ".cen"}, int'(centenas), c);
        chk({tag, ".dec"}, int'(decenas), d);
        chk({tag, ".uni"}, int'(unidades), u);
        chk({tag, ".cnt"}, int'(digit_count), n);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        n_reset   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        acc_value = 10'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_digits("rst", 0, 0, 0, 0);
        chk("rst.cargar", int'(cargar), 0);
        chk("rst.ovf", int'(ovf_err), 0);
        chk("rst.busy", int'(busy), 0);

        @(negedge clk);
        n_reset = 1'b1;

        // 1,2,3,ENTER with acc 0: load 123, exactly one cargar two cycles after ENTER
        press(4'd1);
        chk_digits("first_key", 0, 0, 1, 1);
        press(4'd2);
        press(4'd3);
        chk_digits("k123", 1, 2, 3, 3);
        press(K_ENT);
        chk("k123.check_busy", int'(busy), 1);
        chk("k123.check_cargar", int'(cargar), 0);
        tick();
        chk("k123.load_cargar", int'(cargar), 1);
        chk("k123.load_busy", int'(busy), 1);
        chk_digits("k123.load", 1, 2, 3, 3);
        tick();
        chk("k123.after_cargar", int'(cargar), 0);
        chk("k123.after_busy", int'(busy), 0);
        chk_digits("k123.after", 0, 0, 0, 0);

        // 4th digit rejected
        press(4'd4);
        press(4'd5);
        press(4'd6);
        press(4'd7);
        chk("k4567.ovf", int'(ovf_err), 1);
        chk_digits("k4567", 4, 5, 6, 3);
        tick();
        chk("k4567.ovf_pulse", int'(ovf_err), 0);
        press(K_CLR);
        chk_digits("clr", 0, 0, 0, 0);

        // Backspace then load
        press(4'd9);
        press(4'd8);
        press(K_BS);
        chk_digits("k98bs", 0, 0, 9, 1);
        press(K_ENT);
        tick();
        chk("k98bs.cargar", int'(cargar), 1);
        chk_digits("k98bs.load", 0, 0, 9, 1);
        tick();
        chk("k98bs.after", int'(cargar), 0);
        press(4'd5);
        press(K_BS);
        press(K_BS);
        chk_digits("k5bsbs", 0, 0, 0, 0);
        chk("k5bsbs.busy", int'(busy), 0);
        press(4'd7);
        chk_digits("idle_after_bs", 0, 0, 7, 1);
        press(K_CLR);

        // Range boundary: 900+124 overflows, 900+123 loads
        acc_value = 10'd900;
        press(4'd1);
        press(4'd2);
        press(4'd4);
        press(K_ENT);
        chk("sum1024.busy", int'(busy), 1);
        tick();
        chk("sum1024.ovf", int'(ovf_err), 1);
        chk("sum1024.cargar", int'(cargar), 0);
        chk("sum1024.busy_off", int'(busy), 0);
        chk_digits("sum1024", 0, 0, 0, 0);
        tick();
        chk("sum1024.no_late_cargar", int'(cargar), 0);
        chk("sum1024.ovf_pulse", int'(ovf_err), 0);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(K_ENT);
        tick();
        chk("sum1023.cargar", int'(cargar), 1);
        chk("sum1023.ovf", int'(ovf_err), 0);
        tick();
        acc_value = 10'd0;

        // ENTER in IDLE is ignored
        press(K_ENT);
        chk("idle_enter.busy", int'(busy), 0);
        tick();
        chk("idle_enter.cargar", int'(cargar), 0);

        // CLEAR after two digits
        press(4'd3);
        press(4'd4);
        press(K_CLR);
        chk_digits("clr2", 0, 0, 0, 0);
        tick();
        chk("clr2.cargar", int'(cargar), 0);

        // Ignored codes and key_valid low change nothing
        press(4'd3);
        press(4'hE);
        chk_digits("code_e", 0, 0, 3, 1);
        press(4'hD);
        press(4'hF);
        chk_digits("code_df", 0, 0, 3, 1);
        @(negedge clk);
        key_code = 4'd5;
        tick();
        chk_digits("no_valid", 0, 0, 3, 1);
        press(K_CLR);

        // Key during CHECK dropped
        press(4'd1);
        press(K_ENT);
        chk("check_key.busy", int'(busy), 1);
        press(4'd5);
        chk("check_key.cargar", int'(cargar), 1);
        chk_digits("check_key", 0, 0, 1, 1);
        tick();
        chk("check_key.after", int'(cargar), 0);
        chk_digits("check_key.after", 0, 0, 0, 0);

        // Reset during CHECK aborts the load
        press(4'd2);
        press(K_ENT);
        chk("rst_check.busy", int'(busy), 1);
        #2;
        n_reset = 1'b0;
        #1;
        chk_digits("rst_async", 0, 0, 0, 0);
        chk("rst_async.busy", int'(busy), 0);
        chk("rst_async.cargar", int'(cargar), 0);
        chk("rst_async.ovf", int'(ovf_err), 0);
        tick();
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_check.no_cargar", int'(cargar), 0);
        end
        chk_digits("rst_check.idle", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
